// File: rtl/ksa_wide_add_ctrl_pkg.sv
// Shared definitions for the wide add/subtract sequencer: word width,
// FSM state encoding and a word-select helper.
package ksa_ctrl_pkg;

   localparam int WORD_W    = 16;
   localparam int MAX_WORDS = 16;
   localparam int MAX_W     = WORD_W * MAX_WORDS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Word i of a vector zero-extended to MAX_W bits.
   function automatic logic [WORD_W-1:0] get_word(input logic [MAX_W-1:0] v,
                                                  input int unsigned       i);
      return v[i*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/ksa_wide_add_ctrl_adder.sv
// 16-bit Kogge-Stone prefix adder, purely combinational.
// The carry-in is folded in after the prefix tree: carry into bit i+1 is
// G[i:0] | (P[i:0] & cin).
module KoggeStoneAdder
   import ksa_ctrl_pkg::*;
(
   input  logic [WORD_W-1:0] x,
   input  logic [WORD_W-1:0] y,
   input  logic              cin,
   output logic              cout,
   output logic [WORD_W-1:0] sum
);

   logic [WORD_W-1:0] w_p0;
   logic [WORD_W-1:0] w_g;
   logic [WORD_W-1:0] w_p;
   logic [WORD_W-1:0] w_gn;
   logic [WORD_W-1:0] w_pn;
   logic [WORD_W:0]   w_c;

   // Prefix tree over log2(16)=4 levels, then carries and sum bits.
   always_comb begin
      w_p0 = x ^ y;
      w_g  = x & y;
      w_p  = w_p0;
      w_gn = '0;
      w_pn = '0;
      w_c  = '0;
      for (int lvl = 0; lvl < 4; lvl++) begin
         w_gn = w_g;
         w_pn = w_p;
         for (int i = (1 << lvl); i < WORD_W; i++) begin
            w_gn[i] = w_g[i] | (w_p[i] & w_g[i - (1 << lvl)]);
            w_pn[i] = w_p[i] & w_p[i - (1 << lvl)];
         end
         w_g = w_gn;
         w_p = w_pn;
      end
      w_c[0] = cin;
      for (int i = 0; i < WORD_W; i++) begin
         w_c[i+1] = w_g[i] | (w_p[i] & cin);
      end
   end

   assign sum  = w_p0 ^ w_c[WORD_W-1:0];
   assign cout = w_c[WORD_W];

endmodule

// File: rtl/ksa_wide_add_ctrl.sv
// Wide add/subtract sequencer: feeds one 16-bit Kogge-Stone adder a word
// per cycle, LS word first, chaining the carry through a register.
module ksa_wide_add_ctrl
   import ksa_ctrl_pkg::*;
#(
   parameter  int WORDS = 4,
   localparam int W     = WORD_W * WORDS
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         op_sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         cout,
   output logic         ovf
);

   localparam int IDX_W = $clog2(WORDS);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [W-1:0]      r_a;
   logic [W-1:0]      r_b;
   logic              r_carry;
   logic [IDX_W-1:0]  r_idx;
   logic [W-1:0]      r_result;
   logic              r_cout;
   logic              r_ovf;

   logic [MAX_W-1:0]  w_a_ext;
   logic [MAX_W-1:0]  w_b_ext;
   logic [WORD_W-1:0] w_x;
   logic [WORD_W-1:0] w_y;
   logic [WORD_W-1:0] w_sum;
   logic              w_cout;
   logic              w_last;
   logic              w_ovf;
   logic              w_accept;
   logic [WORDS-1:0]  w_word_we;

   // Zero-extend operands so the package word selector can be shared.
   always_comb begin
      w_a_ext          = '0;
      w_b_ext          = '0;
      w_a_ext[W-1:0]   = r_a;
      w_b_ext[W-1:0]   = r_b;
   end

   assign w_x = get_word(w_a_ext, 32'(r_idx));
   assign w_y = get_word(w_b_ext, 32'(r_idx));

   KoggeStoneAdder u_adder (
      .x    (w_x),
      .y    (w_y),
      .cin  (r_carry),
      .cout (w_cout),
      .sum  (w_sum)
   );

   assign w_last   = (r_idx == IDX_W'(WORDS - 1));
   assign w_accept = (r_state == IDLE) && in_valid;
   // b is already inverted for subtract, so this is the plain add rule.
   assign w_ovf    = (r_a[W-1] == r_b[W-1]) && (w_sum[WORD_W-1] != r_a[W-1]);

   // One-hot write enable for the result word being produced this cycle.
   for (genvar k = 0; k < WORDS; k++) begin : g_we
      assign w_word_we[k] = (r_state == RUN) && (r_idx == IDX_W'(k));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = RUN;
         end
         RUN: begin
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand capture, carry chain, word counter and result/flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a     <= a;
            r_b     <= op_sub ? ~b : b;
            r_carry <= op_sub;
            r_idx   <= '0;
         end
         if (r_state == RUN) begin
            for (int k = 0; k < WORDS; k++) begin
               if (w_word_we[k]) r_result[k*WORD_W +: WORD_W] <= w_sum;
            end
            r_carry <= w_cout;
            if (w_last) begin
               r_cout <= w_cout;
               r_ovf  <= w_ovf;
            end else begin
               r_idx  <= r_idx + 1'b1;
            end
         end
      end
   end

   assign result = r_result;
   assign cout   = r_cout;
   assign ovf    = r_ovf;

endmodule

// File: tb/tb_ksa_wide_add_ctrl.sv
// Directed bench for ksa_wide_add_ctrl at WORDS=4 (64-bit operands).
module tb_ksa_wide_add_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        op_sub;
   logic [63:0] a;
   logic [63:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        cout;
   logic        ovf;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        sub;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic        co;
      logic        ov;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   ksa_wide_add_ctrl #(.WORDS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // After an accept edge: count edges until out_valid, bounded.
   task automatic wait_done(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic start_op(input logic sub, input logic [63:0] va, input logic [63:0] vb,
                           output int lat);
      @(negedge clk);
      in_valid = 1'b1; op_sub = sub; a = va; b = vb;
      chk("in_ready_before_accept", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("in_ready_after_accept", 64'(in_ready), 64'd0);
      wait_done(lat);
   endtask

   task automatic ack();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("out_valid_after_ack", 64'(out_valid), 64'd0);
      chk("in_ready_after_ack", 64'(in_ready), 64'd1);
      out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      vecs[0] = '{1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 64'h0000_0000_0001_0000, 64'h1, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111,
                  64'h2345_6789_ABCD_F001, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[8] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1};
      vecs[9] = '{1'b1, 64'hFFFF_0000_0000_0000, 64'h1, 64'hFFFE_FFFF_FFFF_FFFF, 1'b1, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b0;
      #12;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", result, 64'h0);
      chk("rst_flags", {62'd0, cout, ovf}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven arithmetic checks.
      for (int i = 0; i < 10; i++) begin
         start_op(vecs[i].sub, vecs[i].a, vecs[i].b, lat);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
         chk($sformatf("v%0d_result", i), result, vecs[i].res);
         chk($sformatf("v%0d_cout", i), 64'(cout), 64'(vecs[i].co));
         chk($sformatf("v%0d_ovf", i), 64'(ovf), 64'(vecs[i].ov));
         ack();
      end

      // Backpressure: stay in DONE with outputs frozen while in_valid pulses.
      start_op(1'b0, 64'h1234, 64'h1, lat);
      chk("bp_latency", 64'(lat), 64'd4);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = i[0]; op_sub = 1'b1; a = 64'hDEAD_0000 + 64'(i); b = 64'h77;
         @(posedge clk); #1;
         chk("bp_result", result, 64'h1235);
         chk("bp_flags", {62'd0, cout, ovf}, 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      // Handshake with in_valid held high: accept happens on the following edge.
      @(negedge clk);
      in_valid = 1'b1; op_sub = 1'b0; a = 64'h5; b = 64'h5; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_H_in_ready", 64'(in_ready), 64'd1);
      chk("bp_H_out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_next_accept", 64'(in_ready), 64'd0);
      wait_done(lat);
      chk("bp_next_latency", 64'(lat), 64'd4);
      chk("bp_next_result", result, 64'hA);
      ack();

      // Reset in the middle of RUN, after two words have been written.
      @(negedge clk);
      in_valid = 1'b1; op_sub = 1'b0;
      a = 64'hAAAA_BBBB_CCCC_DDDD; b = 64'h1111_1111_1111_1111;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_result", result, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      start_op(1'b0, 64'h1, 64'h2, lat);
      chk("postrst_latency", 64'(lat), 64'd4);
      chk("postrst_result", result, 64'h3);
      chk("postrst_flags", {62'd0, cout, ovf}, 64'd0);
      ack();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ksa_wide_add_ctrl.md
# ksa_wide_add_ctrl

Multi-cycle sequencer that performs WORDS×16-bit add/subtract by driving one shared 16-bit Kogge-Stone adder one word per cycle, least-significant word first. The carry is chained through a register between words. It sits between a requester using a valid/ready operand interface and a consumer using a valid/ready result interface. It lets wide arithmetic reuse the 16-bit prefix adder instead of instantiating a wide one.

## Interface
- WORDS, default 4: number of 16-bit words per operand; legal range 2..16; operand width W = 16*WORDS.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- op_sub  in  1  0 = a+b, 1 = a−b; sampled on accept.
- a  in  W  operand A; sampled on accept.
- b  in  W  operand B; sampled on accept.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  W  sum/difference, modulo 2^W.
- cout  out  1  final carry out. For subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  two's-complement signed overflow of the W-bit operation.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch a into a_q;
  - latch b into b_q, or ~b when op_sub=1;
  - set carry_q=op_sub;
  - set idx=0;
  - go to RUN.
- RUN, each cycle, adder inputs are x=a_q word[idx], y=b_q word[idx], cin=carry_q.
  - On the edge: result word[idx] ← adder sum, carry_q ← adder cout, idx ← idx+1.
  - When idx=WORDS−1, instead go to DONE.
  - On that final edge, also register cout ← adder cout and ovf.
- ovf = (a_q[W−1] == b_q[W−1]) && (sum[15] of the final word != a_q[W−1]). The check uses the already-inverted b_q.
- DONE: out_valid=1; result, cout and ovf are held stable. On out_ready, go to IDLE; out_valid drops on that edge.
- in_valid is ignored outside IDLE; in_ready=0 there. No queueing.
- idx counter width is $clog2(WORDS). It never wraps within an operation.
- result words not yet written in RUN keep their previous values. They are not observable, because out_valid=0.
- Reset (asynchronous, any state, including mid-RUN):
  - state returns to IDLE; the operation in progress is discarded;
  - in_ready=1 and out_valid=0 while rst_n is low;
  - result, cout, ovf, a_q, b_q, carry_q and idx are cleared to 0.

## Timing
- Accept edge E0 (IDLE, in_valid&in_ready): in_ready goes low after E0.
- Word k is registered on edge E(k+1). out_valid rises after edge E(WORDS).
- Latency from accept to out_valid is WORDS cycles.
- Result handshake edge H (DONE, out_ready): in_ready=1 from H.
- With in_valid held high, the earliest next accept is the edge after H.
- Peak throughput is one operation per WORDS+2 cycles.
- The adder path is purely combinational within one cycle: register → KoggeStoneAdder → register.
- out_ready held low: the block stays in DONE indefinitely with outputs constant.

## Structure
- Shared package ksa_ctrl_pkg holds:
  - localparam WORD_W=16;
  - state enum {IDLE, RUN, DONE};
  - a function extracting word i of a W-bit vector.
- One sub-module instance: KoggeStoneAdder (16-bit, combinational).
  - Ports: x, y, cin, cout, sum.
  - Wiring: x = a word, y = b word, cin = carry_q.
  - It is the only arithmetic in the block.
- Everything else (FSM, word mux, result write-enable decode, ovf logic) is local.

## Test plan
- Add with carry across a word boundary (WORDS=4): a=0x0000_0000_0000_FFFF, b=0x1, op_sub=0.
  - result=0x0000_0000_0001_0000, cout=0, ovf=0;
  - out_valid exactly 4 cycles after accept.
- Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, add.
  - result=0, cout=1, ovf=0.
- Subtract, two cases:
  - a=0x0000_0000_0001_0000, b=0x1 → result=0x0000_0000_0000_FFFF, cout=1, ovf=0;
  - a=0, b=1 → result=0xFFFF_FFFF_FFFF_FFFF, cout=0 (borrow), ovf=0.
- Signed overflow, two cases:
  - a=0x7FFF_FFFF_FFFF_FFFF + b=1 → result=0x8000_0000_0000_0000, ovf=1, cout=0;
  - a=0x8000_0000_0000_0000 − b=1 → result=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid.
  - result, cout and ovf remain constant; in_ready=0; no second accept.
  - After out_ready=1, in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst_n=0 after 2 words of an operation.
  - out_valid=0, in_ready=1 and result=0 immediately, without waiting for a clock edge.
  - After release, a new add 0x1+0x2 returns 0x3 with 4-cycle latency.
